// File: rtl/axi_stream_strip_header.sv
// Removes a 0..DATA_BYTE_WD byte header from each AXI-Stream packet, returns it on a
// side channel and realigns the remaining payload bytes to beat boundaries.
module axi_stream_strip_header #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [DATA_BYTE_WD-1:0] keep_strip,
    output logic                    valid_header,
    input  logic                    ready_header,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_header
);
    localparam int unsigned CNT_WD = $clog2(DATA_BYTE_WD + 1);
    localparam int unsigned SH_WD  = CNT_WD + 3;
    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

    function automatic logic [CNT_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] v);
        logic [CNT_WD-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) n = n + CNT_WD'(v[i]);
        return n;
    endfunction

    // MSB-first contiguous byte mask holding n ones
    function automatic logic [DATA_BYTE_WD-1:0] keep_mask(input logic [CNT_WD-1:0] n);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++)
            if (i < int'(n)) m[int'(DATA_BYTE_WD) - 1 - i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic logic [SH_WD-1:0] byte_shift(input logic [CNT_WD-1:0] n);
        return {n, 3'b000};
    endfunction

    state_t                  state, state_nxt;
    logic [DATA_BYTE_WD-1:0] strip_keep, strip_keep_nxt;
    logic [CNT_WD-1:0]       k_cnt, l_cnt;
    logic [CNT_WD-1:0]       res_cnt, res_cnt_nxt, beat_cnt;
    logic [DATA_WD-1:0]      res_data, res_data_nxt, beat_data;
    logic                    beat_load, beat_last, slot_free;
    logic                    valid_out_nxt, last_out_nxt, valid_header_nxt;
    logic [DATA_WD-1:0]      data_out_nxt, header_out_nxt;
    logic [DATA_BYTE_WD-1:0] keep_out_nxt, keep_header_nxt;

    assign k_cnt     = popcount(strip_keep);
    assign l_cnt     = popcount(keep_in);
    assign slot_free = !valid_out || ready_out;

    // Next-state, handshake and datapath decode
    always_comb begin
        state_nxt        = state;
        strip_keep_nxt   = strip_keep;
        res_data_nxt     = res_data;
        res_cnt_nxt      = res_cnt;
        ready_in         = 1'b0;
        ready_strip      = 1'b0;
        beat_load        = 1'b0;
        beat_last        = 1'b0;
        beat_cnt         = '0;
        beat_data        = '0;
        valid_out_nxt    = valid_out && !ready_out;
        data_out_nxt     = data_out;
        keep_out_nxt     = keep_out;
        last_out_nxt     = last_out;
        valid_header_nxt = valid_header && !ready_header;
        header_out_nxt   = header_out;
        keep_header_nxt  = keep_header;

        case (state)
            IDLE: begin
                ready_strip = 1'b1;
                if (valid_strip) begin
                    strip_keep_nxt = keep_strip;
                    state_nxt      = FIRST;
                end
            end
            FIRST: begin
                ready_in = slot_free && (!valid_header || ready_header);
                if (valid_in && ready_in) begin
                    valid_header_nxt = 1'b1;
                    header_out_nxt   = data_in >> byte_shift(FULL_CNT - k_cnt);
                    keep_header_nxt  = strip_keep;
                    if (last_in) begin
                        if (l_cnt > k_cnt) begin
                            beat_load = 1'b1;
                            beat_last = 1'b1;
                            beat_cnt  = l_cnt - k_cnt;
                            beat_data = data_in << byte_shift(k_cnt);
                        end
                        res_data_nxt = '0;
                        res_cnt_nxt  = '0;
                        state_nxt    = IDLE;
                    end else begin
                        if (k_cnt == '0) begin
                            beat_load    = 1'b1;
                            beat_cnt     = FULL_CNT;
                            beat_data    = data_in;
                            res_data_nxt = '0;
                            res_cnt_nxt  = '0;
                        end else begin
                            res_data_nxt = data_in << byte_shift(k_cnt);
                            res_cnt_nxt  = FULL_CNT - k_cnt;
                        end
                        state_nxt = BODY;
                    end
                end
            end
            BODY: begin
                ready_in = slot_free;
                if (valid_in && ready_in) begin
                    beat_load = 1'b1;
                    if (k_cnt == '0) begin
                        // pass-through: plain register slice
                        beat_data = data_in;
                        beat_cnt  = last_in ? l_cnt : FULL_CNT;
                        beat_last = last_in;
                        if (last_in) state_nxt = IDLE;
                    end else begin
                        beat_data    = res_data | (data_in >> byte_shift(res_cnt));
                        res_data_nxt = data_in << byte_shift(k_cnt);
                        beat_cnt     = FULL_CNT;
                        if (last_in && l_cnt <= k_cnt) begin
                            beat_cnt     = res_cnt + l_cnt;
                            beat_last    = 1'b1;
                            res_data_nxt = '0;
                            res_cnt_nxt  = '0;
                            state_nxt    = IDLE;
                        end else if (last_in) begin
                            res_cnt_nxt = l_cnt - k_cnt;
                            state_nxt   = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    beat_load    = 1'b1;
                    beat_last    = 1'b1;
                    beat_cnt     = res_cnt;
                    beat_data    = res_data;
                    res_data_nxt = '0;
                    res_cnt_nxt  = '0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (beat_load) begin
            valid_out_nxt = 1'b1;
            keep_out_nxt  = keep_mask(beat_cnt);
            data_out_nxt  = beat_data & byte_mask(keep_out_nxt);
            last_out_nxt  = beat_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            strip_keep   <= '0;
            res_data     <= '0;
            res_cnt      <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            header_out   <= '0;
            keep_header  <= '0;
        end else begin
            state        <= state_nxt;
            strip_keep   <= strip_keep_nxt;
            res_data     <= res_data_nxt;
            res_cnt      <= res_cnt_nxt;
            valid_out    <= valid_out_nxt;
            data_out     <= data_out_nxt;
            keep_out     <= keep_out_nxt;
            last_out     <= last_out_nxt;
            valid_header <= valid_header_nxt;
            header_out   <= header_out_nxt;
            keep_header  <= keep_header_nxt;
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: a byte-stream reference model queues the
// expected header and payload beats, and an independent monitor compares what the DUT emits.
module tb_axi_stream_strip_header;
    localparam int unsigned W  = 32;
    localparam int unsigned WB = 4;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [WB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [WB-1:0] keep;
    } hdr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [W-1:0]  data_in = '0;
    logic [WB-1:0] keep_in = '0;
    logic          last_in = 1'b0;
    logic          valid_out;
    logic          ready_out = 1'b1;
    logic [W-1:0]  data_out;
    logic [WB-1:0] keep_out;
    logic          last_out;
    logic          valid_strip = 1'b0;
    logic          ready_strip;
    logic [WB-1:0] keep_strip = '0;
    logic          valid_header;
    logic          ready_header = 1'b1;
    logic [W-1:0]  header_out;
    logic [WB-1:0] keep_header;

    int n_vec = 0;
    int n_err = 0;
    int bp_mode = 0;
    int hcnt = 0;

    beat_t         exp_out[$];
    hdr_t          exp_hdr[$];
    logic [W-1:0]  pk_data[$];
    logic [WB-1:0] pk_keep[$];

    beat_t         mon_e;
    hdr_t          mon_h;
    logic          out_stall = 1'b0;
    logic          hdr_stall = 1'b0;
    logic [W+WB+1:0] out_prev = '0;
    logic [W+WB:0]   hdr_prev = '0;

    axi_stream_strip_header #(.DATA_WD(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .keep_in(keep_in), .last_in(last_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .keep_out(keep_out), .last_out(last_out),
        .valid_strip(valid_strip), .ready_strip(ready_strip), .keep_strip(keep_strip),
        .valid_header(valid_header), .ready_header(ready_header),
        .header_out(header_out), .keep_header(keep_header)
    );

    always #5 clk = ~clk;

    // Sink backpressure: mode 0 always ready, mode 1 random payload stalls and a 5-cycle header delay
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) begin
            ready_out    = 1'b1;
            ready_header = 1'b1;
            hcnt         = 0;
        end else begin
            ready_out = ($urandom_range(0, 3) != 0);
            if (valid_header && !ready_header) hcnt++;
            else hcnt = 0;
            ready_header = (hcnt >= 5);
        end
    end

    // Monitor: outputs are stable by the falling edge; a handshake seen here completes on the next rise
    always @(negedge clk) begin
        if (!rst_n) begin
            out_stall = 1'b0;
            hdr_stall = 1'b0;
        end else begin
            if (out_stall) begin
                n_vec++;
                if ({valid_out, data_out, keep_out, last_out} !== out_prev) begin
                    n_err++;
                    $display("FAIL out_stable: got %h, held value was %h",
                             {valid_out, data_out, keep_out, last_out}, out_prev);
                end
            end
            if (hdr_stall) begin
                n_vec++;
                if ({valid_header, header_out, keep_header} !== hdr_prev) begin
                    n_err++;
                    $display("FAIL hdr_stable: got %h, held value was %h",
                             {valid_header, header_out, keep_header}, hdr_prev);
                end
            end
            if (valid_out && ready_out) begin
                n_vec++;
                if (exp_out.size() == 0) begin
                    n_err++;
                    $display("FAIL out_extra: got data=%h keep=%b last=%b, expected no beat",
                             data_out, keep_out, last_out);
                end else begin
                    mon_e = exp_out.pop_front();
                    if (data_out !== mon_e.data || keep_out !== mon_e.keep || last_out !== mon_e.last) begin
                        n_err++;
                        $display("FAIL out_beat: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                                 data_out, keep_out, last_out, mon_e.data, mon_e.keep, mon_e.last);
                    end
                end
            end
            if (valid_header && ready_header) begin
                n_vec++;
                if (exp_hdr.size() == 0) begin
                    n_err++;
                    $display("FAIL hdr_extra: got header=%h keep=%b, expected none", header_out, keep_header);
                end else begin
                    mon_h = exp_hdr.pop_front();
                    if (header_out !== mon_h.data || keep_header !== mon_h.keep) begin
                        n_err++;
                        $display("FAIL hdr: got header=%h keep=%b, expected header=%h keep=%b",
                                 header_out, keep_header, mon_h.data, mon_h.keep);
                    end
                end
            end
            out_stall = valid_out && !ready_out;
            out_prev  = {valid_out, data_out, keep_out, last_out};
            hdr_stall = valid_header && !ready_header;
            hdr_prev  = {valid_header, header_out, keep_header};
        end
    end

    // Reference model: the packet is a byte stream; the first K byte lanes of beat 0 are the
    // header and every byte after them is repacked MSB-first into full beats.
    task automatic model_packet(input int k);
        logic [7:0]   bytes[$];
        logic [W-1:0] d;
        logic [WB-1:0] kp;
        logic [W-1:0] h;
        beat_t        e;
        hdr_t         he;
        int           idx;
        int           n;
        for (int b = 0; b < pk_data.size(); b++) begin
            d  = pk_data[b];
            kp = pk_keep[b];
            for (int i = 0; i < int'(WB); i++)
                if (kp[int'(WB) - 1 - i]) bytes.push_back(d[W-1-8*i -: 8]);
        end
        d = pk_data[0];
        h = '0;
        for (int i = 0; i < k; i++) h = {h[W-9:0], d[W-1-8*i -: 8]};
        he.data = h;
        he.keep = WB'((1 << k) - 1);
        exp_hdr.push_back(he);
        idx = k;
        while (idx < bytes.size()) begin
            n = bytes.size() - idx;
            if (n > int'(WB)) n = int'(WB);
            e.data = '0;
            for (int j = 0; j < n; j++) e.data[W-1-8*j -: 8] = bytes[idx + j];
            e.keep = WB'(4'hF << (int'(WB) - n));
            e.last = (idx + n >= bytes.size());
            exp_out.push_back(e);
            idx += n;
        end
    endtask

    task automatic send_strip(input logic [WB-1:0] ks);
        int t;
        t = 0;
        valid_strip = 1'b1;
        keep_strip  = ks;
        @(negedge clk);
        while (!ready_strip && t < 1000) begin @(negedge clk); t++; end
        n_vec++;
        if (!ready_strip) begin
            n_err++;
            $display("FAIL strip_timeout: ready_strip=%b after %0d cycles, expected 1", ready_strip, t);
        end
        @(posedge clk); #1;
        valid_strip = 1'b0;
        keep_strip  = '0;
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic [WB-1:0] kp, input logic lst);
        int t;
        t = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = kp;
        last_in  = lst;
        @(negedge clk);
        while (!ready_in && t < 1000) begin @(negedge clk); t++; end
        n_vec++;
        if (!ready_in) begin
            n_err++;
            $display("FAIL in_timeout: ready_in=%b after %0d cycles, expected 1", ready_in, t);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = '0;
        keep_in  = '0;
        last_in  = 1'b0;
    endtask

    task automatic run_packet(input int k, input int gap_max);
        int g;
        model_packet(k);
        send_strip(WB'((1 << k) - 1));
        for (int b = 0; b < pk_data.size(); b++) begin
            g = $urandom_range(0, gap_max);
            for (int j = 0; j < g; j++) begin @(posedge clk); #1; end
            drive_beat(pk_data[b], pk_keep[b], b == pk_data.size() - 1);
        end
    endtask

    task automatic load_beat(input logic [W-1:0] d, input logic [WB-1:0] kp);
        pk_data.push_back(d);
        pk_keep.push_back(kp);
    endtask

    task automatic load_case1();
        pk_data.delete(); pk_keep.delete();
        load_beat(32'hEEDDCCAA, 4'b1111);
        load_beat(32'hBBCCDDEE, 4'b1111);
        load_beat(32'hFF001122, 4'b1111);
        load_beat(32'h33445566, 4'b1111);
        load_beat(32'h77889900, 4'b1111);
        load_beat(32'hAA000000, 4'b1000);
    endtask

    task automatic check_reset_state(input string tag);
        n_vec++;
        if (valid_out !== 1'b0 || last_out !== 1'b0 || valid_header !== 1'b0 ||
            ready_in !== 1'b0 || ready_strip !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ctrl: got vo=%b lo=%b vh=%b rin=%b rstrip=%b, expected 0 0 0 0 1", tag,
                     valid_out, last_out, valid_header, ready_in, ready_strip);
        end
        n_vec++;
        if (data_out !== '0 || keep_out !== '0 || header_out !== '0 || keep_header !== '0) begin
            n_err++;
            $display("FAIL %s_data: got data=%h keep=%b hdr=%h hkeep=%b, expected all zero", tag,
                     data_out, keep_out, header_out, keep_header);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, want);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_out.size() != 0 || exp_hdr.size() != 0) && t < 2000) begin
            @(negedge clk); t++;
        end
        n_vec++;
        if (exp_out.size() != 0 || exp_hdr.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d beats and %0d headers outstanding, expected 0",
                     exp_out.size(), exp_hdr.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        int nb;
        int len;
        logic [W-1:0]  d;
        logic [WB-1:0] kp;

        #2 rst_n = 1'b0;
        #10 check_reset_state("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        bp_mode = 0;
        load_case1();
        run_packet(3, 0);

        // K=1 packet that needs the FLUSH beat
        pk_data.delete(); pk_keep.delete();
        load_beat(32'h11223344, 4'b1111);
        load_beat(32'h55667788, 4'b1110);
        run_packet(1, 0);
        @(negedge clk);
        check_bit("flush_ready_in", ready_in, 1'b0);
        check_bit("flush_busy", ready_strip, 1'b0);
        @(negedge clk);
        check_bit("flush_done", ready_strip, 1'b1);
        @(posedge clk); #1;

        pk_data.delete(); pk_keep.delete();
        load_beat(32'h01020304, 4'b1111);
        load_beat(32'h05060000, 4'b1100);
        run_packet(0, 0);

        pk_data.delete(); pk_keep.delete();
        load_beat(32'h12345678, 4'b1111);
        run_packet(4, 0);
        @(negedge clk);
        check_bit("k4_idle", ready_strip, 1'b1);
        @(posedge clk); #1;
        drain();

        bp_mode = 1;
        load_case1();
        run_packet(3, 2);
        drain();

        // Reset while beat 3 of case 1 is offered
        bp_mode = 0;
        @(posedge clk); #1;
        load_case1();
        model_packet(3);
        send_strip(4'b0111);
        drive_beat(pk_data[0], pk_keep[0], 1'b0);
        drive_beat(pk_data[1], pk_keep[1], 1'b0);
        valid_in = 1'b1; data_in = pk_data[2]; keep_in = pk_keep[2]; last_in = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0;
        #1 check_reset_state("midpkt_reset");
        exp_out.delete();
        exp_hdr.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        load_case1();
        run_packet(3, 1);
        drain();

        for (int p = 0; p < 40; p++) begin
            bp_mode = $urandom_range(0, 1);
            k   = $urandom_range(0, 4);
            nb  = $urandom_range(1, 6);
            len = $urandom_range(1, 4);
            pk_data.delete(); pk_keep.delete();
            for (int b = 0; b < nb; b++) begin
                d  = $urandom;
                kp = (b == nb - 1) ? WB'(4'hF << (4 - len)) : 4'hF;
                for (int i = 0; i < int'(WB); i++)
                    if (!kp[int'(WB) - 1 - i]) d[W-1-8*i -: 8] = 8'h00;
                load_beat(d, kp);
            end
            run_packet(k, (bp_mode == 1) ? 2 : 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Receive-side counterpart of `axi_stream_insert_header`. It removes a leading header of 0..DATA_BYTE_WD bytes from each AXI-Stream packet and realigns the remaining payload to beat boundaries. The removed header is returned on a separate header channel. The block sits at the receive end of a link whose transmit end prepends headers with `axi_stream_insert_header`, so a back-to-back pair round-trips the original payload.

## Interface
- `DATA_WD`, 32, stream data width in bits; must be a multiple of 8.
- `DATA_BYTE_WD`, DATA_WD/8, bytes per beat.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `valid_in` / `ready_in` input / output 1: input beat handshake.
- `data_in` input DATA_WD: input beat; byte 0 is `[DATA_WD-1:DATA_WD-8]` (MSB first).
- `keep_in` input DATA_BYTE_WD: byte valid mask, MSB-first contiguous; not all-ones only on the last beat.
- `last_in` input 1: last beat of the packet.
- `valid_out` / `ready_out` output / input 1: output beat handshake.
- `data_out` output DATA_WD: realigned payload beat; invalid bytes are driven 0.
- `keep_out` output DATA_BYTE_WD: MSB-first contiguous mask.
- `last_out` output 1: last payload beat.
- `valid_strip` / `ready_strip` input / output 1: per-packet strip-length handshake.
- `keep_strip` input DATA_BYTE_WD: LSB-contiguous ones; popcount K is the number of header bytes to remove (0..DATA_BYTE_WD).
- `valid_header` / `ready_header` output / input 1: extracted-header handshake.
- `header_out` output DATA_WD: removed header bytes, right-aligned in the same format as `header_insert`; unused upper bytes are 0.
- `keep_header` output DATA_BYTE_WD: equals the accepted `keep_strip`.

## Operation
- The FSM has four states: IDLE, FIRST, BODY, FLUSH.
  - IDLE: `ready_strip`=1 and `ready_in`=0. When `valid_strip` is high, K is latched and the FSM moves to FIRST.
  - FIRST: `ready_in` = output slot free AND (`!valid_header` || `ready_header`).
    - On acceptance, the K MSB bytes of the beat load `header_out`/`keep_header` and `valid_header` is set.
    - The remaining W-K bytes load the residual register, with residual count R = W-K.
    - If K=0, the beat is forwarded directly as an output beat (pass-through mode).
    - If `last_in` is set: emit residual bytes min(L,W)-K as the final beat (L = popcount `keep_in`). If that count is ≤0, no payload beat is emitted. Go to IDLE.
    - Otherwise go to BODY.
  - BODY: each accepted beat with L valid bytes produces {residual R bytes, first K bytes of the beat}. The residual becomes the beat's last W-K bytes.
    - On `last_in` with L≤K: emit one final beat carrying R+L bytes with `last_out`=1, then go to IDLE.
    - On `last_in` with L>K: emit a full beat, then go to FLUSH, keeping L-K residual bytes.
  - FLUSH: `ready_in`=0. Emit the residual (L-K bytes) with `last_out`=1, then go to IDLE.
- In pass-through mode (K=0) the block is a 1-deep register slice: no residual is held and FLUSH is never entered.
- The header channel holds its value until `ready_header`. It is independent of the payload output channel except for the FIRST-state stall above.
- K latched for a packet is constant until that packet's last beat is accepted (FLUSH included).

## Timing
- Reset values:
  - FSM in IDLE.
  - `valid_out`, `last_out`, `valid_header`, `ready_in` = 0; `ready_strip` = 1.
  - `data_out`, `keep_out`, `header_out`, `keep_header` = 0.
  - Residual register and residual count = 0.
- Output beats are registered: an output beat appears the cycle after the input beat that completes it is accepted.
- The output slot is free when `!valid_out` || `ready_out`. With `ready_out` held high, throughput is 1 beat/cycle, except one bubble on `ready_in` for the FLUSH beat.
- The header appears the cycle after the first beat is accepted.
- `valid_out`/`data_out`/`keep_out`/`last_out` are stable while `valid_out` && !`ready_out`.
- `valid_strip` is ignored outside IDLE. The next packet's strip handshake may occur in the cycle after the last output beat is loaded.
- Reset asserted mid-packet: all state is dropped immediately, and the partial packet and header are discarded.

## Test plan
- Round trip, W=32, K=3 (`keep_strip`=0111):
  - Stimulus: input EEDDCCAA, BBCCDDEE, FF001122, 33445566, 77889900, AA000000 (`keep_in` 1000, last).
  - Required: `header_out`=00EEDDCC, `keep_header`=0111; output AABBCCDD, EEFF0011, 22334455, 66778899, 00AA0000 (`keep_out` 1100, last).
- FLUSH, K=1:
  - Stimulus: input 11223344, then 55667788 (`keep_in` 1110, last).
  - Required: `header_out`=00000011; output 22334455, then 66770000 (`keep_out` 1100, last); `ready_in` low for exactly 1 cycle.
- K=0: input 01020304, then 05060000 (`keep_in` 1100, last) -> identical output, `keep_header`=0000.
- K=4, single-beat packet 12345678 (last, `keep_in` 1111) -> `header_out`=12345678, no payload beat, FSM returns to IDLE.
- Backpressure: case 1 with `ready_out` toggled randomly and `ready_header` delayed 5 cycles -> same beats in order, outputs stable while stalled, no beat lost or duplicated.
- Reset mid-packet: `rst_n` low during beat 3 of case 1 -> all outputs 0 and `ready_strip`=1 at once; a following packet processes correctly.
